// File: rtl/if1_pc_gen.sv
// if1_pc_gen -- IF1 fetch PC generator with a direct-mapped BTB predictor.
//
// Holds the architectural fetch PC and predicts the next fetch PC from a
// direct-mapped branch target buffer with 2-bit saturating counters. It
// applies stalls and redirects from the hazard controller. EX trains the BTB
// with each resolved branch.
//
// Parameters:
//   RESET_PC     fetch PC after reset
//   BTB_ENTRIES  BTB depth (power of 2, >= 2)
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   pc_wen          PC advance enable (0 = stall)
//   pc_is_wrong     redirect request, honoured only with pc_wen=1
//   pc_correct      redirect target, loaded verbatim
//   upd_valid       one-cycle branch resolution strobe from EX
//   upd_pc          PC of the resolved branch
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   if1_pc          registered fetch PC
//   if1_branch_bp   predicted taken for if1_pc
//   if1_pc_bp       predicted next fetch PC
//   if1_valid       fetch PC valid (low until the first edge after reset)
module if1_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wen,
  input  logic        pc_is_wrong,
  input  logic [31:0] pc_correct,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] if1_pc,
  output logic        if1_branch_bp,
  output logic [31:0] if1_pc_bp,
  output logic        if1_valid
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [29:0]     btb_target [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  // Lookup on the current fetch PC against registered contents (no bypass).
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;

  assign lk_idx = if1_pc[IDX+1:2];
  assign lk_tag = if1_pc[31:IDX+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  assign if1_branch_bp = lk_hit && btb_ctr[lk_idx][1];
  assign if1_pc_bp     = if1_branch_bp ? {btb_target[lk_idx], 2'b00} : if1_pc + 32'd4;

  // Training side.
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic [1:0]      up_ctr;
  logic [1:0]      up_ctr_next;

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[31:IDX+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  assign up_ctr = btb_ctr[up_idx];

  always_comb begin
    up_ctr_next = up_ctr;
    if (upd_taken) begin
      if (up_ctr != 2'b11) up_ctr_next = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr_next = up_ctr - 2'd1;
    end
  end

  // Targets are word aligned; the low bits of upd_target carry no information.
  logic unused_target_bits;
  assign unused_target_bits = ^upd_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        btb_ctr[up_idx] <= up_ctr_next;
        if (upd_taken) btb_target[up_idx] <= upd_target[31:2];
      end else if (upd_taken) begin
        // Miss and taken: allocate, evicting whatever aliases to this index.
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= upd_target[31:2];
        btb_ctr[up_idx]    <= 2'b10;
      end
    end
  end

  // PC register: the first edge after reset only raises if1_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if1_pc    <= RESET_PC;
      if1_valid <= 1'b0;
    end else if (!if1_valid) begin
      if1_valid <= 1'b1;
    end else if (pc_wen) begin
      if1_pc <= pc_is_wrong ? pc_correct : if1_pc_bp;
    end
  end

endmodule
